// File: rtl/shared_mem_arbiter.sv
// Single-port word memory shared by N_CH requesters with byte-masked writes and a
// LATENCY-cycle access. Define ARB_FIXED_PRIO_EN for fixed priority (default: round-robin).
module shared_mem_arbiter #(
    parameter int N_CH    = 2,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_CH-1:0]            i_request,
    input  logic [N_CH-1:0]            i_we_re,
    input  logic [N_CH*DATA_W/8-1:0]   i_mask,
    input  logic [N_CH*ADDR_W-1:0]     i_address,
    input  logic [N_CH*DATA_W-1:0]     i_data_in,
    output logic [N_CH-1:0]            o_valid,
    output logic [DATA_W-1:0]          o_data_out,
    output logic                       o_busy
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t              r_state;
    logic [CH_W-1:0]     r_grant;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_we;
    logic [NB-1:0]       r_mask;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [CH_W-1:0]     w_win;
    logic                w_grant;
    logic                w_commit;

    assign w_grant  = (r_state == S_IDLE) && (|i_request);
    // A reset edge that coincides with the commit edge suppresses the write.
    assign w_commit = i_rst && (r_state == S_BUSY) && (r_cnt == '0) && r_we;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        w_win = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i_request[i]) w_win = CH_W'(i);
        end
    end
`else
    logic [CH_W-1:0] r_last;
    logic            w_found;
    int              w_idx;

    // Search starts one past the last granted channel and wraps.
    always_comb begin
        w_win   = r_last;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= N_CH; k++) begin
            w_idx = (int'(r_last) + k) % N_CH;
            if (!w_found && i_request[w_idx]) begin
                w_win   = CH_W'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst)       r_last <= CH_W'(N_CH - 1);
        else if (w_grant) r_last <= w_win;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_cnt      <= '0;
            o_valid    <= '0;
            o_data_out <= '0;
            o_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_valid <= '0;
                    if (w_grant) begin
                        r_grant <= w_win;
                        r_we    <= i_we_re[w_win];
                        r_mask  <= i_mask[int'(w_win)*NB +: NB];
                        r_addr  <= i_address[int'(w_win)*ADDR_W +: ADDR_W];
                        r_wdata <= i_data_in[int'(w_win)*DATA_W +: DATA_W];
                        r_cnt   <= CNT_W'(LATENCY - 1);
                        o_busy  <= 1'b1;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        if (!r_we) o_data_out <= r_mem[r_addr];
                        o_valid          <= '0;
                        o_valid[r_grant] <= 1'b1;
                        r_state          <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    o_valid <= '0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_valid <= '0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            for (int b = 0; b < NB; b++) begin
                if (r_mask[b]) r_mem[r_addr][b*8 +: 8] <= r_wdata[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Randomized bench for shared_mem_arbiter against a transaction-level model
// (array memory, rotating-priority winner rule, fixed grant-to-valid latency).
module tb_shared_mem_arbiter;
    localparam int N_CH    = 2;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int LATENCY = 3;
    localparam int NB      = DATA_W / 8;
    localparam int DEPTH   = 1 << ADDR_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_CH-1:0]          request;
    logic [N_CH-1:0]          we_re;
    logic [N_CH*NB-1:0]       mask;
    logic [N_CH*ADDR_W-1:0]   address;
    logic [N_CH*DATA_W-1:0]   data_in;
    logic [N_CH-1:0]          valid;
    logic [DATA_W-1:0]        data_out;
    logic                     busy;

    shared_mem_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .i_clk(clk), .i_rst(rst), .i_request(request), .i_we_re(we_re), .i_mask(mask),
        .i_address(address), .i_data_in(data_in), .o_valid(valid), .o_data_out(data_out),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    logic              t_we   [N_CH];
    logic [NB-1:0]     t_mask [N_CH];
    logic [ADDR_W-1:0] t_addr [N_CH];
    logic [DATA_W-1:0] t_data [N_CH];

    logic [DATA_W-1:0] m_mem [DEPTH];
    logic [DATA_W-1:0] m_dout;
    int                m_last;
    int                n_chk = 0;
    int                n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic we, input logic [NB-1:0] m,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        t_we[c] = we; t_mask[c] = m; t_addr[c] = a; t_data[c] = d;
        we_re[c]                   = we;
        mask[c*NB +: NB]           = m;
        address[c*ADDR_W +: ADDR_W] = a;
        data_in[c*DATA_W +: DATA_W] = d;
    endtask

    // One full access: grant, LATENCY-cycle wait, valid pulse, return to idle.
    task automatic do_txn(input logic [N_CH-1:0] req, input bit drop);
        int  w;
        bit  found;
        w = 0;
        found = 0;
`ifdef ARB_FIXED_PRIO_EN
        for (int i = N_CH - 1; i >= 0; i--) if (req[i]) w = i;
`else
        for (int k = 1; k <= N_CH; k++) begin
            int c;
            c = (m_last + k) % N_CH;
            if (!found && req[c]) begin w = c; found = 1; end
        end
        m_last = w;
`endif
        request = req;
        @(posedge clk); #1;
        chk("grant_busy", busy, 1);
        chk("grant_valid", valid, 0);
        if (drop) request = '0;
        for (int k = 1; k <= LATENCY; k++) begin
            @(posedge clk); #1;
            if (k < LATENCY) chk("inflight_valid", valid, 0);
        end
        if (t_we[w]) begin
            for (int b = 0; b < NB; b++)
                if (t_mask[w][b]) m_mem[t_addr[w]][b*8 +: 8] = t_data[w][b*8 +: 8];
        end else begin
            m_dout = m_mem[t_addr[w]];
        end
        chk("resp_valid", valid, 64'(1) << w);
        chk("resp_dout", data_out, m_dout);
        chk("resp_busy", busy, 1);
        @(posedge clk); #1;
        chk("idle_valid", valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b0;
        request = '1;
        we_re = '0; mask = '0; address = '0; data_in = '0;
        for (int c = 0; c < N_CH; c++) set_ch(c, 1'b0, '0, '0, '0);
        m_last = N_CH - 1;
        m_dout = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_valid", valid, 0);
            chk("rst_dout", data_out, 0);
            chk("rst_busy", busy, 0);
        end
        request = '0;
        rst = 1'b1;

        // Give every model word a known value.
        for (int a = 0; a < DEPTH; a++) begin
            set_ch(0, 1'b1, '1, ADDR_W'(a), $urandom);
            do_txn(2'b01, 0);
        end

        set_ch(0, 1'b1, 4'b1111, 4'd5, 32'hDEADBEEF);
        do_txn(2'b01, 0);
        set_ch(0, 1'b0, 4'b0000, 4'd5, '0);
        do_txn(2'b01, 0);
        chk("full_word_read", data_out, 32'hDEADBEEF);

        set_ch(0, 1'b1, 4'b1111, 4'd7, 32'h11223344);
        do_txn(2'b01, 0);
        set_ch(0, 1'b1, 4'b0101, 4'd7, 32'hAABBCCDD);
        do_txn(2'b01, 0);
        set_ch(0, 1'b0, 4'b0000, 4'd7, '0);
        do_txn(2'b01, 0);
        chk("partial_write", data_out, 32'h11BB33DD);

        set_ch(0, 1'b0, 4'b0000, 4'd5, '0);
        set_ch(1, 1'b0, 4'b0000, 4'd7, '0);
        for (int i = 0; i < 4; i++) do_txn(2'b11, 0);

        // Abort an in-flight write with reset.
        set_ch(1, 1'b1, 4'b1111, 4'd9, 32'h12345678);
        do_txn(2'b10, 0);
        set_ch(1, 1'b1, 4'b1111, 4'd9, 32'h00000055);
        request = 2'b10;
        @(posedge clk); #1;
        chk("abort_busy", busy, 1);
        rst = 1'b0;
        request = '0;
        for (int i = 0; i < LATENCY + 1; i++) begin
            @(posedge clk); #1;
            chk("abort_valid", valid, 0);
            chk("abort_busy_clr", busy, 0);
            chk("abort_dout", data_out, 0);
        end
        rst = 1'b1;
        m_last = N_CH - 1;
        m_dout = '0;
        set_ch(0, 1'b0, 4'b0000, 4'd9, '0);
        do_txn(2'b01, 0);
        chk("abort_old_value", data_out, 32'h12345678);

        set_ch(0, 1'b0, 4'b0000, 4'd5, '0);
        do_txn(2'b01, 1);

        for (int n = 0; n < 300; n++) begin
            for (int c = 0; c < N_CH; c++)
                set_ch(c, 1'($urandom_range(0, 1)), NB'($urandom_range(0, 15)),
                       ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom);
            do_txn(N_CH'($urandom_range(1, 3)), $urandom_range(0, 7) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
